// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared constants and state encoding for the music sequencer and display decoders
package music_pkg;
   localparam int NOTE_W = 6;
   localparam int ROW_W  = 24;
   localparam int CNT_W  = 25;

   localparam logic [NOTE_W-1:0] REST = '0;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_PLAY   = 3'd3;
   localparam logic [2:0] ST_PAUSED = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_LOAD   = ST_LOAD,
      S_PLAY   = ST_PLAY,
      S_PAUSED = ST_PAUSED
   } state_t;
endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - 25-bit step counter with period latch and terminal-count flag
module step_timer
   import music_pkg::*;
#(
   parameter int TICKS_PER_STEP = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       en,
   input  logic [1:0] tempo_sel,
   output logic       done
);
   localparam logic [CNT_W-1:0] BASE = CNT_W'(TICKS_PER_STEP);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] period;

   // period is captured only on load so a tempo change never alters the running step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         period <= BASE;
      end else if (load) begin
         count  <= '0;
         period <= BASE >> tempo_sel;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   // fires three counts early to cover the FETCH and LOAD cycles of the next row
   assign done = (count == period - CNT_W'(3));
endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - song ROM step sequencer driving the four note buses
module music_sequencer
   import music_pkg::*;
#(
   parameter int TICKS_PER_STEP = 25_000_000,
   parameter int SONG_LEN       = 64
) (
   input  logic              EGO1_Clock,
   input  logic              reset,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [1:0]        tempo_sel,
   output logic [5:0]        rom_addr,
   input  logic [ROW_W-1:0]  rom_data,
   output logic [NOTE_W-1:0] track0,
   output logic [NOTE_W-1:0] track1,
   output logic [NOTE_W-1:0] track2,
   output logic [NOTE_W-1:0] track3,
   output logic [5:0]        step,
   output logic              playing,
   output logic              song_done
);
   localparam logic [5:0] LAST = 6'(SONG_LEN - 1);

   state_t state, state_next;
   logic   tc, timer_en, song_end;

   step_timer #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_timer (
      .clk       (EGO1_Clock),
      .rst       (reset),
      .load      (state == S_LOAD),
      .en        (timer_en),
      .tempo_sel (tempo_sel),
      .done      (tc)
   );

   always_ff @(posedge EGO1_Clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      timer_en   = 1'b0;
      song_end   = 1'b0;
      case (state)
         S_IDLE:  if (play) state_next = S_FETCH;
         S_FETCH: state_next = stop ? S_IDLE : S_LOAD;
         S_LOAD:  state_next = stop ? S_IDLE : S_PLAY;
         S_PLAY: begin
            // holding at terminal count lets a pause taken on that cycle resume into the step end
            timer_en = !tc;
            if (stop) begin
               state_next = S_IDLE;
            end else if (pause) begin
               state_next = S_PAUSED;
            end else if (tc) begin
               if (step == LAST && !loop_en) begin
                  state_next = S_IDLE;
                  song_end   = 1'b1;
               end else begin
                  state_next = S_FETCH;
               end
            end
         end
         S_PAUSED: begin
            if (stop)      state_next = S_IDLE;
            else if (play) state_next = S_PLAY;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge EGO1_Clock or posedge reset) begin
      if (reset) begin
         rom_addr  <= '0;
         step      <= '0;
         track0    <= REST;
         track1    <= REST;
         track2    <= REST;
         track3    <= REST;
         song_done <= 1'b0;
      end else begin
         song_done <= song_end;
         if (state != S_IDLE && state_next == S_IDLE) begin
            rom_addr <= '0;
            step     <= '0;
            track0   <= REST;
            track1   <= REST;
            track2   <= REST;
            track3   <= REST;
         end else if (state == S_LOAD) begin
            track0 <= rom_data[NOTE_W-1:0];
            track1 <= rom_data[2*NOTE_W-1:NOTE_W];
            track2 <= rom_data[3*NOTE_W-1:2*NOTE_W];
            track3 <= rom_data[4*NOTE_W-1:3*NOTE_W];
            step   <= rom_addr;
         end else if (state == S_PLAY && state_next == S_FETCH) begin
            rom_addr <= (step == LAST) ? 6'd0 : step + 6'd1;
         end
      end
   end

   assign playing = (state == S_FETCH) || (state == S_LOAD) || (state == S_PLAY);
endmodule
